// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pipe_pkg : opcode encoding and helpers for alu_pipe. Rev 1.0
// ------------------------------------------------------------------
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_ACC   = 3'd5,
    OP_ALOAD = 3'd6,
    OP_NOP   = 3'd7
  } alu_op_e;

  function automatic logic op_writes_acc(alu_op_e op);
    return (op == OP_ACC) || (op == OP_ALOAD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pipe_if : command/result handshake bundle for alu_pipe. Rev 1.0
// ------------------------------------------------------------------
interface alu_pipe_if #(
  parameter int WIDTH = 8
);

  logic                  in_valid;
  logic                  in_ready;
  alu_pipe_pkg::alu_op_e in_op;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_result;
  logic                  out_carry;
  logic                  out_overflow;
  logic                  out_zero;

  // master = command producer plus result consumer; slave = the ALU
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_overflow, out_zero
  );

endinterface
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_core : combinational ALU datapath with accumulator next-state. Rev 1.0
// ------------------------------------------------------------------
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] acc_next,
  output logic             acc_we
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] acc_sum;

  // one extra bit so carry/borrow falls out of the top bit
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign acc_sum = {1'b0, acc_in} + {1'b0, a};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    acc_next = acc_in;
    case (op)
      OP_ADD: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ACC: begin
        result   = acc_sum[WIDTH-1:0];
        carry    = acc_sum[WIDTH];
        overflow = (acc_in[WIDTH-1] == a[WIDTH-1]) && (acc_sum[WIDTH-1] != acc_in[WIDTH-1]);
        acc_next = acc_sum[WIDTH-1:0];
      end
      OP_ALOAD: begin
        result   = a;
        acc_next = a;
      end
      default: ;
    endcase
  end

  assign acc_we = op_writes_acc(op);
  assign zero   = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_pipe : two-stage valid/ready pipelined ALU with accumulator. Rev 1.0
// ------------------------------------------------------------------
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  alu_pipe_if.slave  bus
);

  typedef struct packed {
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_cmd_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
  } s2_res_t;

  logic             s1_valid_q, s1_valid_d;
  s1_cmd_t          s1_cmd_q, s1_cmd_d;
  logic             s2_valid_q, s2_valid_d;
  s2_res_t          s2_res_q, s2_res_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s1_ready;
  logic             s2_ready;
  logic             accept;
  logic             advance;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_overflow;
  logic             core_zero;
  logic [WIDTH-1:0] core_acc_next;
  logic             core_acc_we;

  // ready depends only on held state and out_ready, never on in_valid
  assign s2_ready = !s2_valid_q || bus.out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign accept   = bus.in_valid && s1_ready;
  assign advance  = s1_valid_q && s2_ready;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op       (s1_cmd_q.op),
    .a        (s1_cmd_q.a),
    .b        (s1_cmd_q.b),
    .acc_in   (acc_q),
    .result   (core_result),
    .carry    (core_carry),
    .overflow (core_overflow),
    .zero     (core_zero),
    .acc_next (core_acc_next),
    .acc_we   (core_acc_we)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cmd_d   = s1_cmd_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    acc_d      = acc_q;

    if (advance) s1_valid_d = 1'b0;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_cmd_d   = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
    end

    if (bus.out_ready) s2_valid_d = 1'b0;
    // the accumulator moves only with the command, so a stalled ACC never re-applies
    if (advance) begin
      s2_valid_d = 1'b1;
      s2_res_d   = '{result: core_result, carry: core_carry,
                     overflow: core_overflow, zero: core_zero};
      if (core_acc_we) acc_d = core_acc_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_cmd_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cmd_q   <= s1_cmd_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      acc_q      <= acc_d;
    end
  end

  assign bus.in_ready     = s1_ready;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_result   = s2_res_q.result;
  assign bus.out_carry    = s2_res_q.carry;
  assign bus.out_overflow = s2_res_q.overflow;
  assign bus.out_zero     = s2_res_q.zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_pipe : directed self-checking bench for alu_pipe (WIDTH=8). Rev 1.0
// ------------------------------------------------------------------
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // expected packing: {result[7:0], carry, overflow, zero}
  alu_op_e    s_op [20] = '{OP_SUB, OP_SUB, OP_ADD, OP_NOP, OP_ALOAD, OP_ACC, OP_ACC, OP_AND, OP_OR, OP_XOR,
                            OP_ACC, OP_ACC, OP_ACC, OP_ADD, OP_SUB, OP_SUB, OP_ALOAD, OP_AND, OP_ACC, OP_XOR};
  logic [7:0] s_a  [20] = '{8'h05, 8'h80, 8'h7F, 8'h12, 8'h03, 8'h04, 8'h05, 8'hF0, 8'h0F, 8'hAA,
                            8'hF4, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h10, 8'hFF, 8'h01, 8'h0F};
  logic [7:0] s_b  [20] = '{8'h07, 8'h01, 8'h01, 8'h34, 8'hFF, 8'h00, 8'h00, 8'h3C, 8'h30, 8'hAA,
                            8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hF0};
  logic [10:0] s_exp [20] = '{{8'hFE, 3'b100}, {8'h7F, 3'b010}, {8'h80, 3'b010}, {8'h00, 3'b001},
                              {8'h03, 3'b000}, {8'h07, 3'b000}, {8'h0C, 3'b000}, {8'h30, 3'b000},
                              {8'h3F, 3'b000}, {8'h00, 3'b001}, {8'h00, 3'b101}, {8'h80, 3'b000},
                              {8'h00, 3'b111}, {8'h00, 3'b101}, {8'h00, 3'b001}, {8'h80, 3'b110},
                              {8'h10, 3'b000}, {8'h00, 3'b001}, {8'h11, 3'b000}, {8'hFF, 3'b000}};

  alu_op_e    b_op [10] = '{OP_ADD, OP_ACC, OP_ACC, OP_SUB, OP_XOR, OP_ACC, OP_ALOAD, OP_ACC, OP_OR, OP_ACC};
  logic [7:0] b_a  [10] = '{8'h10, 8'h01, 8'h02, 8'h20, 8'h14, 8'hEC, 8'h7F, 8'h01, 8'h80, 8'h80};
  logic [7:0] b_b  [10] = '{8'h20, 8'h00, 8'h00, 8'h21, 8'h14, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
  logic [10:0] b_exp [10] = '{{8'h30, 3'b000}, {8'h12, 3'b000}, {8'h14, 3'b000}, {8'hFF, 3'b100},
                              {8'h00, 3'b001}, {8'h00, 3'b101}, {8'h7F, 3'b000}, {8'h80, 3'b010},
                              {8'h81, 3'b000}, {8'h00, 3'b111}};

  function automatic logic [10:0] obs_out();
    return {bus.out_result, bus.out_carry, bus.out_overflow, bus.out_zero};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  initial begin
    int sent;
    int got;
    int cyc;

    bus.in_valid  = 1'b0;
    bus.in_op     = OP_NOP;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // reset held across two edges, then released between edges
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_outputs", 32'(obs_out()), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;

    drive(OP_ADD, 8'hF0, 8'h20);
    #1;
    chk("add_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("add_not_yet_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_result", 32'(obs_out()), 32'({8'h10, 3'b100}));

    // 20 back-to-back commands, one result per cycle
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        drive(s_op[i], s_a[i], s_b[i]);
        #1;
        chk($sformatf("thru_in_ready[%0d]", i), 32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("thru_valid[%0d]", i - 1), 32'(bus.out_valid), 32'd1);
        chk($sformatf("thru_res[%0d]", i - 1), 32'(obs_out()), 32'(s_exp[i - 1]));
      end
    end
    tick();
    chk("thru_drained", 32'(bus.out_valid), 32'd0);

    // 10 commands with the consumer stalled for cycles 3..7
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 10 && cyc < 60) begin
      bus.out_ready = !(cyc >= 3 && cyc <= 7);
      if (sent < 10) drive(b_op[sent], b_a[sent], b_b[sent]);
      else bus.in_valid = 1'b0;
      #1;
      if (cyc >= 3 && cyc <= 7) chk($sformatf("bp_in_ready_low[%0d]", cyc), 32'(bus.in_ready), 32'd0);
      if (cyc == 8) chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
      if (bus.out_valid) begin
        chk($sformatf("bp_res[%0d]@%0d", got, cyc), 32'(obs_out()), 32'(b_exp[got]));
        if (bus.out_ready) got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      cyc++;
    end
    chk("bp_all_results", 32'(got), 32'd10);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // two commands in flight (ALOAD in S2, ACC in S1), then an async reset pulse
    drive(OP_ALOAD, 8'h05, 8'h00);
    tick();
    drive(OP_ACC, 8'h02, 8'h00);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_outputs", 32'(obs_out()), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    #2;
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    drive(OP_ACC, 8'h01, 8'h00);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_s1_only", 32'(bus.out_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_acc", 32'(obs_out()), 32'({8'h01, 3'b000}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
